usart_rx: RTL and testbench
===========================

# usart_rx

Receive half of the USART: recovers 8N1 asynchronous frames from `rx_pin` using 16x oversampling and a majority vote at mid-bit, then holds the received byte for a consumer behind a ready/latch handshake. It sits beside `usart_tx` in the USART library, on the same serial link, and its consumer-side handshake mirrors `usart_tx`'s `latch_in`/`ready`/`done`. The oversampled clock is generated externally at 16x the baud rate.

## Interface
- `DATA_BITS`, default 8: data bits per frame, sent LSB first.
- `OVERSAMPLE`, default 16: clock cycles per bit. The vote indices below assume 16.

- `bit_clock_x16`  input  1  Sole clock, 16x the baud rate.
- `reset`  input  1  Synchronous, active-high reset.
- `rx_pin`  input  1  Asynchronous serial line. Idles high.
- `data_out`  output  DATA_BITS  Last accepted byte. Stable while `ready`=1.
- `ready`  output  1  A byte is available in `data_out`.
- `latch_out`  input  1  Consumer takes the byte. Ignored while `ready`=0.
- `done`  output  1  One-cycle pulse for each valid frame received.
- `frame_error`  output  1  One-cycle pulse when a stop bit is bad.
- `overrun`  output  1  Sticky flag: a valid frame was dropped because `ready` was still 1.

## Operation
- **Input synchroniser:** `rx_pin` passes through 2 flops to form `rx_sync`. Both flops reset to 1.
- **Sample counter:** `sample_count` (4 bits) holds the index, 0–15, of the current sample within the current bit window.
- **Majority vote:** samples at indices 7, 8 and 9 are voted 2-of-3. The vote is resolved on the edge that processes index 9.
- **IDLE:**
  - `rx_sync`=0 → START, with `sample_count`←1. The detecting cycle counts as index 0.
- **START:**
  - At index 9, vote=1 → IDLE (false start, no flags raised).
  - At index 15 → DATA, with `bit_index`←0 and `sample_count`←0.
- **DATA:**
  - At index 9, the vote is shifted into the MSB of the shift register, which shifts right.
  - At index 15, `bit_index`++.
  - After bit DATA_BITS-1 completes its window → STOP.
- **STOP:** resolved at index 9 with no wait for index 15, so the receiver can resynchronise to an early next start bit.
  - Vote=1 and `ready`=0, or `latch_out`=1 on this same edge: `data_out`←shift register, `ready`←1, `done` pulses, → IDLE.
  - Vote=1, `ready`=1 and no `latch_out`: the byte is dropped, `data_out` is unchanged, `overrun`←1, `done` pulses, → IDLE.
  - Vote=0: `frame_error` pulses, the byte is discarded, → WAIT_HIGH.
- **WAIT_HIGH:**
  - Stays until `rx_sync`=1, then → IDLE. A continuous break therefore produces exactly one `frame_error`.
- **Handshake:**
  - `latch_out` while `ready`=1 → `ready`←0 and `overrun`←0 on that edge.
  - Simultaneous `latch_out` and a valid stop: the new byte is loaded, `ready` stays 1 and `overrun` is not set.
- **Reset:** forces IDLE and clears the counters.
  - Reset value of every output: `data_out`=0, `ready`=0, `done`=0, `frame_error`=0, `overrun`=0.
  - Reset applied mid-frame discards the partial frame. The receiver then needs `rx_sync` to go high and fall again before it accepts a new frame.

## Timing
- `rx_sync` lags `rx_pin` by 2 edges.
- If `rx_pin` is first sampled low at edge E0, IDLE detects the start at E2.
- With DATA_BITS=8, `ready` and `done` assert after edge E2+153 (16 + 128 + 9 samples).
- `done` and `frame_error` are high for exactly 1 cycle.
- `ready` is level: it holds until the edge that accepts `latch_out`.
- The earliest next start detection is the edge after the STOP vote.
- Tolerated baud mismatch: about ±3% (the vote window stays inside the bit).

## Structure
- Shared package `usart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - the vote indices (7, 8, 9) and the last-sample index (15);
  - `OVERSAMPLE`.
- One natural sub-module: `usart_sync_vote`, containing the 2-flop synchroniser plus the 3-sample majority voter. It exposes `rx_sync` and `vote`.

## Test plan
- **Clean frame:** drive 0xAA 8N1 at 16 cycles/bit, idle high before and after → `data_out`=0xAA; `ready` and `done` rise after E2+153; `frame_error`=0.
- **Noise and false start:**
  - Single-cycle glitch low at index 8 of data bit 3 (value 1) while receiving 0x5A → the vote still yields 0x5A.
  - 5-cycle low pulse on an idle line → no `done`, no `ready`, back to IDLE.
- **Framing error and break:**
  - Send 0x3C with the stop bit low → one `frame_error` pulse, `ready` stays 0.
  - Line held low for 400 cycles → exactly one `frame_error`, then 0x3C received normally after the line returns high.
- **Overrun:**
  - Receive 0x11, then 0x22, without `latch_out` → `data_out`=0x11, `overrun`=1.
  - Pulse `latch_out` → `ready`=0, `overrun`=0.
- **Latch race:** assert `latch_out` on the STOP edge of 0x22 while holding 0x11 → `data_out`=0x22, `ready`=1, `overrun`=0.
- **Back-to-back and reset:**
  - Receive 0x01 then 0xFF with no idle gap, and `latch_out` pulsed once per byte → both bytes delivered, in order.
  - Assert `reset` during data bit 4 → all outputs at their reset values; the next clean frame (0x99) is received correctly.

Source files
------------

// File: rtl/usart_pkg.sv
// Shared definitions for the USART receive path: FSM states, oversampling
// constants and the mid-bit vote sample positions.
package usart_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int VOTE_IDX_A  = 7;
    localparam int VOTE_IDX_B  = 8;
    localparam int VOTE_IDX_C  = 9;
    localparam int LAST_SAMPLE = 15;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/usart_sync_vote.sv
// Two-flop synchroniser for the serial line plus a 2-of-3 mid-bit voter.
// The vote is only meaningful on the cycle that processes the last vote index.
module usart_sync_vote #(
    parameter int SC_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rx_pin_i,
    input  logic [SC_W-1:0] sample_count_i,
    output logic            rx_sync_o,
    output logic            vote_o
);
    import usart_pkg::*;

    logic sync1_q, sync2_q;
    logic smp_a_q, smp_b_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            smp_a_q <= 1'b1;
            smp_b_q <= 1'b1;
        end else begin
            sync1_q <= rx_pin_i;
            sync2_q <= sync1_q;
            if (sample_count_i == SC_W'(VOTE_IDX_A)) smp_a_q <= sync2_q;
            if (sample_count_i == SC_W'(VOTE_IDX_B)) smp_b_q <= sync2_q;
        end
    end

    // Third sample is taken live so the vote resolves on the index-9 edge itself.
    assign rx_sync_o = sync2_q;
    assign vote_o    = maj3(smp_a_q, smp_b_q, sync2_q);

endmodule

// File: rtl/usart_rx.sv
// 8N1 asynchronous receiver with 16x oversampling and a ready/latch consumer
// handshake; flags framing errors and dropped frames.
module usart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = usart_pkg::OVERSAMPLE
) (
    input  logic                 bit_clock_x16,
    input  logic                 reset,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 ready,
    input  logic                 latch_out,
    output logic                 done,
    output logic                 frame_error,
    output logic                 overrun
);
    import usart_pkg::*;

    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BI_W = $clog2(DATA_BITS);
    localparam logic [SC_W-1:0] SC_VOTE = SC_W'(VOTE_IDX_C);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);

    rx_state_e            state_q;
    logic [SC_W-1:0]      sample_count_q;
    logic [BI_W-1:0]      bit_index_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 ready_q, done_q, frame_err_q, overrun_q;
    logic                 rx_sync, vote;

    usart_sync_vote #(.SC_W(SC_W)) u_sync_vote (
        .clk_i          (bit_clock_x16),
        .rst_i          (reset),
        .rx_pin_i       (rx_pin),
        .sample_count_i (sample_count_q),
        .rx_sync_o      (rx_sync),
        .vote_o         (vote)
    );

    always_ff @(posedge bit_clock_x16) begin
        if (reset) begin
            state_q        <= IDLE;
            sample_count_q <= '0;
            bit_index_q    <= '0;
            shift_q        <= '0;
            data_q         <= '0;
            ready_q        <= 1'b0;
            done_q         <= 1'b0;
            frame_err_q    <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            done_q         <= 1'b0;
            frame_err_q    <= 1'b0;
            sample_count_q <= sample_count_q + 1'b1;
            if (latch_out && ready_q) begin
                ready_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    sample_count_q <= '0;
                    if (!rx_sync) begin
                        state_q        <= START;
                        sample_count_q <= SC_W'(1);
                    end
                end
                START: begin
                    if (sample_count_q == SC_VOTE && vote) begin
                        state_q        <= IDLE;
                        sample_count_q <= '0;
                    end else if (sample_count_q == SC_LAST) begin
                        state_q        <= DATA;
                        bit_index_q    <= '0;
                        sample_count_q <= '0;
                    end
                end
                DATA: begin
                    if (sample_count_q == SC_VOTE)
                        shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                    if (sample_count_q == SC_LAST) begin
                        sample_count_q <= '0;
                        if (bit_index_q == BI_LAST) state_q <= STOP;
                        else                        bit_index_q <= bit_index_q + 1'b1;
                    end
                end
                STOP: begin
                    // Resolve mid stop bit so an early next start edge is not missed.
                    if (sample_count_q == SC_VOTE) begin
                        sample_count_q <= '0;
                        if (vote) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                            if (!ready_q || latch_out) begin
                                data_q  <= shift_q;
                                ready_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    sample_count_q <= '0;
                    if (rx_sync) state_q <= IDLE;
                end
                default: begin
                    state_q        <= IDLE;
                    sample_count_q <= '0;
                end
            endcase
        end
    end

    assign data_out    = data_q;
    assign ready       = ready_q;
    assign done        = done_q;
    assign frame_error = frame_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_usart_rx.sv
// Directed bench for usart_rx: clean, glitched, false-start, framing, break,
// overrun, latch race, back-to-back and mid-frame reset cases.
module tb_usart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_pin;
    logic       latch_out;
    logic [7:0] data_out;
    logic       ready, done, frame_error, overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e0    = 0;
    int done_cnt = 0, fe_cnt = 0, done_cyc = 0;

    usart_rx dut (
        .bit_clock_x16 (clk),
        .reset         (reset),
        .rx_pin        (rx_pin),
        .data_out      (data_out),
        .ready         (ready),
        .latch_out     (latch_out),
        .done          (done),
        .frame_error   (frame_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (frame_error) fe_cnt = fe_cnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_pin = 1'b1;
            latch_out = 1'b0;
        end
    endtask

    task automatic do_latch();
        @(negedge clk);
        latch_out = 1'b1;
        @(negedge clk);
        latch_out = 1'b0;
    endtask

    // Cell 0 is the start bit, 1..8 data, 9 stop; each cell is 16 edges.
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input int g_cell, input int g_k,
                              input int l_cell, input int l_k);
        logic [9:0] f;
        f = {stop_b, d, 1'b0};
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                rx_pin    = (c == g_cell && k == g_k) ? ~f[c] : f[c];
                latch_out = (c == l_cell && k == l_k);
                if (c == 0 && k == 0) e0 = cyc + 1;
            end
        end
        latch_out = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_pin = 1'b1; latch_out = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_data", data_out, 0);
        chk("rst_ready", ready, 0);
        chk("rst_done", done, 0);
        chk("rst_fe", frame_error, 0);
        chk("rst_ovr", overrun, 0);
        reset = 1'b0;
        idle(20);

        // clean frame and latency
        send_frame(8'hAA, 1'b1, -1, -1, -1, -1);
        idle(16);
        chk("aa_data", data_out, 8'hAA);
        chk("aa_ready", ready, 1);
        chk("aa_done_cnt", done_cnt, 1);
        chk("aa_latency", done_cyc, e0 + 155);
        chk("aa_fe", fe_cnt, 0);
        do_latch();
        chk("aa_latch_ready", ready, 0);

        // single-cycle glitch at index 8 of data bit 3
        send_frame(8'h5A, 1'b1, 4, 8, -1, -1);
        idle(16);
        chk("glitch_data", data_out, 8'h5A);
        chk("glitch_done_cnt", done_cnt, 2);
        do_latch();

        // 5-cycle false start
        repeat (5) begin @(negedge clk); rx_pin = 1'b0; end
        idle(60);
        chk("false_done_cnt", done_cnt, 2);
        chk("false_ready", ready, 0);

        // bad stop bit
        send_frame(8'h3C, 1'b0, -1, -1, -1, -1);
        idle(32);
        chk("ferr_cnt", fe_cnt, 1);
        chk("ferr_ready", ready, 0);
        chk("ferr_done_cnt", done_cnt, 2);

        // 400-cycle break, then a normal frame
        repeat (400) begin @(negedge clk); rx_pin = 1'b0; end
        idle(32);
        chk("break_fe_cnt", fe_cnt, 2);
        send_frame(8'h3C, 1'b1, -1, -1, -1, -1);
        idle(16);
        chk("after_break_data", data_out, 8'h3C);
        chk("after_break_ready", ready, 1);
        chk("after_break_fe", fe_cnt, 2);
        do_latch();

        // overrun
        send_frame(8'h11, 1'b1, -1, -1, -1, -1);
        idle(16);
        send_frame(8'h22, 1'b1, -1, -1, -1, -1);
        idle(16);
        chk("ovr_data", data_out, 8'h11);
        chk("ovr_flag", overrun, 1);
        chk("ovr_ready", ready, 1);
        chk("ovr_done_cnt", done_cnt, 5);
        do_latch();
        chk("ovr_latch_ready", ready, 0);
        chk("ovr_latch_flag", overrun, 0);

        // latch coinciding with the stop vote edge
        send_frame(8'h11, 1'b1, -1, -1, -1, -1);
        idle(16);
        chk("race_pre_data", data_out, 8'h11);
        send_frame(8'h22, 1'b1, -1, -1, 9, 11);
        idle(16);
        chk("race_data", data_out, 8'h22);
        chk("race_ready", ready, 1);
        chk("race_ovr", overrun, 0);
        do_latch();

        // back-to-back, one latch per byte
        send_frame(8'h01, 1'b1, -1, -1, -1, -1);
        chk("b2b_first", data_out, 8'h01);
        send_frame(8'hFF, 1'b1, -1, -1, 0, 0);
        idle(16);
        chk("b2b_second", data_out, 8'hFF);
        chk("b2b_ready", ready, 1);
        chk("b2b_ovr", overrun, 0);
        chk("b2b_done_cnt", done_cnt, 9);

        // reset during data bit 4, with a byte still pending
        for (int i = 0; i < 5 * 16 + 8; i++) begin
            @(negedge clk);
            rx_pin = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        rx_pin = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_ovr", overrun, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_fe", frame_error, 0);
        reset = 1'b0;
        idle(32);
        send_frame(8'h99, 1'b1, -1, -1, -1, -1);
        idle(16);
        chk("post_rst_data", data_out, 8'h99);
        chk("post_rst_ready", ready, 1);
        chk("post_rst_done_cnt", done_cnt, 10);
        chk("post_rst_fe_cnt", fe_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
